// File: rtl/max_select_nbit_ncc.sv
// Stream consumer of the g >= e comparison: tracks the running maximum winner, its index and source,
// and counts g wins. Optional macro MAX_SELECT_TIE_LAST_EN makes equal winners move the max to the later beat.
module max_select_nbit_ncc #(
    parameter int N     = 8,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [N-1:0]     g_input,
    input  logic [N-1:0]     e_input,
    output logic             cmp_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     max_val,
    output logic [IDX_W-1:0] max_idx,
    output logic             max_src,
    output logic [IDX_W-1:0] g_wins,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] beat_cnt;
    logic             accept;
    logic             ge;
    logic [N-1:0]     w;
    logic             upd;
    logic             take_max;
    logic             last_idx;

    assign in_ready = (state == RUN);
    assign accept   = in_valid && in_ready;
    assign ge       = (g_input >= e_input);
    assign w        = ge ? g_input : e_input;
    assign last_idx = &beat_cnt;

`ifdef MAX_SELECT_TIE_LAST_EN
    assign upd = (w >= max_val);
`else
    assign upd = (w > max_val);
`endif

    // beat 0 always seeds the maximum, whatever the previous stream left behind
    assign take_max = (beat_cnt == '0) || upd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            cmp_o     <= 1'b0;
            out_valid <= 1'b0;
            max_val   <= '0;
            max_idx   <= '0;
            max_src   <= 1'b0;
            g_wins    <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        beat_cnt  <= '0;
                        g_wins    <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        cmp_o    <= ge;
                        beat_cnt <= beat_cnt + IDX_W'(1);
                        if (take_max) begin
                            max_val <= w;
                            max_idx <= beat_cnt;
                            max_src <= ~ge;
                        end
                        if (ge && !(&g_wins))
                            g_wins <= g_wins + IDX_W'(1);
                        // final index without in_last means the stream was truncated
                        if (in_last || last_idx) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            ovf       <= last_idx && !in_last;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_max_select_nbit_ncc.sv
// Scoreboard bench for max_select_nbit_ncc: default instance plus an IDX_W=2 instance for overflow.
module tb_max_select_nbit_ncc;

    typedef struct packed {
        logic [7:0] mv;
        logic [7:0] mi;
        logic       ms;
        logic [7:0] gw;
        logic       ovf;
        logic       cmp;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start = 0, in_valid = 0, in_last = 0, out_ready = 0;
    logic       in_ready, cmp_o, out_valid, max_src, ovf;
    logic [7:0] g_input = 0, e_input = 0, max_val, max_idx, g_wins;

    logic       b_start = 0, b_in_valid = 0, b_in_last = 0, b_out_ready = 0;
    logic       b_in_ready, b_cmp_o, b_out_valid, b_max_src, b_ovf;
    logic [7:0] b_g_input = 0, b_e_input = 0, b_max_val;
    logic [1:0] b_max_idx, b_g_wins;

    max_select_nbit_ncc #(.N(8), .IDX_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .g_input(g_input), .e_input(e_input), .cmp_o(cmp_o),
        .out_valid(out_valid), .out_ready(out_ready), .max_val(max_val), .max_idx(max_idx),
        .max_src(max_src), .g_wins(g_wins), .ovf(ovf)
    );

    max_select_nbit_ncc #(.N(8), .IDX_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_last(b_in_last), .g_input(b_g_input), .e_input(b_e_input), .cmp_o(b_cmp_o),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .max_val(b_max_val), .max_idx(b_max_idx),
        .max_src(b_max_src), .g_wins(b_g_wins), .ovf(b_ovf)
    );

    res_t got;
    assign got = {max_val, max_idx, max_src, g_wins, ovf, cmp_o};

    int   tests = 0;
    int   failed = 0;
    res_t exp_q[$];
    logic [7:0] bg[0:15];
    logic [7:0] be[0:15];

    function automatic res_t model(input int n);
        res_t r = '0;
        logic       ge;
        logic [7:0] w;
        logic       upd;
        for (int i = 0; i < n; i++) begin
            ge = bg[i] >= be[i];
            w  = ge ? bg[i] : be[i];
`ifdef MAX_SELECT_TIE_LAST_EN
            upd = w >= r.mv;
`else
            upd = w > r.mv;
`endif
            if (i == 0 || upd) begin
                r.mv = w;
                r.mi = 8'(i);
                r.ms = !ge;
            end
            if (ge && r.gw != 8'hFF) r.gw = r.gw + 8'd1;
            r.cmp = ge;
        end
        return r;
    endfunction

    task automatic set_beat(input int i, input logic [7:0] g, input logic [7:0] e);
        bg[i] = g;
        be[i] = e;
    endtask

    task automatic send_a(input int n, input bit gaps);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 0; in_last = 1;
                g_input = 8'($urandom); e_input = 8'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1; g_input = bg[i]; e_input = be[i]; in_last = (i == n - 1);
            @(posedge clk); #1;
        end
        in_valid = 0; in_last = 0;
    endtask

    task automatic wait_a(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_a();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        tests++;
        if (got !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL reset_a: got %h ov=%b rdy=%b, expected 0", got, out_valid, in_ready);
            failed++;
        end
        tests++;
        if ({b_max_val, b_max_idx, b_max_src, b_g_wins, b_ovf, b_cmp_o, b_out_valid, b_in_ready} !== '0) begin
            $display("FAIL reset_b: got nonzero outputs, expected 0");
            failed++;
        end
    endtask

    task automatic test_basic();
        int lat;
        res_t e;
        set_beat(0, 8'hA9, 8'h7B); set_beat(1, 8'h74, 8'hFD); set_beat(2, 8'hAA, 8'hAA);
        exp_q.push_back('{mv:8'hFD, mi:8'd1, ms:1'b1, gw:8'd2, ovf:1'b0, cmp:1'b1});
        send_a(3, 0);
        wait_a(lat);
        tests++;
        if (lat !== 0) begin
            $display("FAIL basic_latency: got %0d extra cycles, expected 0", lat);
            failed++;
        end
        e = exp_q.pop_front();
        tests++;
        if (got !== e) begin
            $display("FAIL basic_result: got %h expected %h", got, e);
            failed++;
        end
        release_a();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL basic_release: got ov=%b rdy=%b expected 0 0", out_valid, in_ready);
            failed++;
        end
    endtask

    task automatic test_tie();
        int lat;
        res_t e;
        set_beat(0, 8'h50, 8'h10); set_beat(1, 8'h30, 8'h50);
`ifdef MAX_SELECT_TIE_LAST_EN
        exp_q.push_back('{mv:8'h50, mi:8'd1, ms:1'b1, gw:8'd1, ovf:1'b0, cmp:1'b0});
`else
        exp_q.push_back('{mv:8'h50, mi:8'd0, ms:1'b0, gw:8'd1, ovf:1'b0, cmp:1'b0});
`endif
        send_a(2, 0);
        wait_a(lat);
        e = exp_q.pop_front();
        tests++;
        if (lat !== 0 || got !== e) begin
            $display("FAIL tie: got %h (lat %0d) expected %h", got, lat, e);
            failed++;
        end
        release_a();
    endtask

    task automatic test_backpressure();
        int lat;
        res_t e;
        set_beat(0, 8'hA9, 8'h7B); set_beat(1, 8'h74, 8'hFD); set_beat(2, 8'hAA, 8'hAA);
        exp_q.push_back('{mv:8'hFD, mi:8'd1, ms:1'b1, gw:8'd2, ovf:1'b0, cmp:1'b1});
        send_a(3, 0);
        wait_a(lat);
        e = exp_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            start = 1; in_valid = 1; in_last = 1; g_input = 8'hFF; e_input = 8'h00;
            @(posedge clk); #1;
            tests++;
            if (got !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                $display("FAIL hold_c%0d: got %h ov=%b rdy=%b expected %h 1 0", c, got, out_valid, in_ready, e);
                failed++;
            end
        end
        start = 0; in_valid = 0; in_last = 0;
        release_a();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || got !== e) begin
            $display("FAIL bp_release: got %h ov=%b rdy=%b expected %h 0 0", got, out_valid, in_ready, e);
            failed++;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] og[0:3];
        logic [7:0] oe[0:3];
        og[0] = 8'h01; oe[0] = 8'h02; og[1] = 8'h03; oe[1] = 8'h00;
        og[2] = 8'h07; oe[2] = 8'h07; og[3] = 8'h00; oe[3] = 8'h09;
        b_start = 1;
        @(posedge clk); #1;
        b_start = 0;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1; b_in_last = 0; b_g_input = og[i]; b_e_input = oe[i];
            @(posedge clk); #1;
        end
        b_in_valid = 0;
        tests++;
        if (b_out_valid !== 1'b1 || b_ovf !== 1'b1 || b_max_val !== 8'h09 || b_max_idx !== 2'd3 ||
            b_max_src !== 1'b1 || b_g_wins !== 2'd2 || b_in_ready !== 1'b0) begin
            $display("FAIL overflow: got ov=%b ovf=%b mv=%h mi=%0d ms=%b gw=%0d expected 1 1 09 3 1 2",
                     b_out_valid, b_ovf, b_max_val, b_max_idx, b_max_src, b_g_wins);
            failed++;
        end
        b_out_ready = 1;
        @(posedge clk); #1;
        b_out_ready = 0;
        tests++;
        if (b_out_valid !== 1'b0) begin
            $display("FAIL overflow_release: got ov=%b expected 0", b_out_valid);
            failed++;
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        res_t e;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        in_valid = 1; g_input = 8'hA9; e_input = 8'h7B; @(posedge clk); #1;
        in_valid = 1; g_input = 8'h74; e_input = 8'hFD; @(posedge clk); #1;
        in_valid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        tests++;
        if (got !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL mid_reset: got %h ov=%b rdy=%b expected 0", got, out_valid, in_ready);
            failed++;
        end
        seen = 0;
        in_valid = 1; in_last = 1; g_input = 8'h11; e_input = 8'h22;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 || in_ready === 1'b1) seen++;
        end
        in_valid = 0; in_last = 0;
        tests++;
        if (seen !== 0) begin
            $display("FAIL mid_reset_quiet: got %0d active cycles expected 0", seen);
            failed++;
        end
        set_beat(0, 8'hA9, 8'h7B); set_beat(1, 8'h74, 8'hFD); set_beat(2, 8'hAA, 8'hAA);
        exp_q.push_back('{mv:8'hFD, mi:8'd1, ms:1'b1, gw:8'd2, ovf:1'b0, cmp:1'b1});
        send_a(3, 0);
        wait_a(lat);
        e = exp_q.pop_front();
        tests++;
        if (lat !== 0 || got !== e) begin
            $display("FAIL mid_reset_fresh: got %h (lat %0d) expected %h", got, lat, e);
            failed++;
        end
        release_a();
    endtask

    task automatic test_single();
        int lat;
        res_t e;
        set_beat(0, 8'h00, 8'h00);
        exp_q.push_back('{mv:8'h00, mi:8'd0, ms:1'b0, gw:8'd1, ovf:1'b0, cmp:1'b1});
        send_a(1, 0);
        wait_a(lat);
        e = exp_q.pop_front();
        tests++;
        if (lat !== 0 || got !== e) begin
            $display("FAIL single: got %h (lat %0d) expected %h", got, lat, e);
            failed++;
        end
        release_a();
    endtask

    task automatic test_back_to_back();
        int lat;
        int n;
        res_t e;
        for (int s = 0; s < 6; s++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++)
                set_beat(i, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
            exp_q.push_back(model(n));
            send_a(n, 1);
            wait_a(lat);
            e = exp_q.pop_front();
            tests++;
            if (lat !== 0 || got !== e) begin
                $display("FAIL stream%0d: got %h (lat %0d) expected %h", s, got, lat, e);
                failed++;
            end
            release_a();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_single();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
